atm_ledger: RTL and testbench



---
 rtl/atm_ledger.sv | 185 ++++++++++++++++++
 tb/tb_atm_ledger.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/atm_ledger.sv
// atm_ledger: register-file account ledger serving one request at a time.
// Request and response ports use valid/ready handshakes. A request transfers
// on a rising edge where req_valid && req_ready; a response transfers on a
// rising edge where resp_valid && resp_ready. The requester holds its payload
// stable until accepted. The ledger holds its response stable until accepted.
module atm_ledger #(
    parameter int NUM_ACCOUNTS = 16,
    parameter int BAL_W = 10,
    parameter logic [BAL_W-1:0] INIT_BAL = 10'd214,
    parameter logic [BAL_W-1:0] WD_LIMIT = 10'd500,
    localparam int AW = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [AW-1:0]    req_src,
    input  logic [AW-1:0]    req_dst,
    input  logic [BAL_W-1:0] req_amt,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [1:0]       resp_status,
    output logic [BAL_W-1:0] resp_balance,
    output logic [15:0]      txn_count,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] OP_BAL  = 2'b00;
    localparam logic [1:0] OP_WD   = 2'b01;
    localparam logic [1:0] OP_DEP  = 2'b10;
    localparam logic [1:0] OP_XFER = 2'b11;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_INSUF = 2'b01;
    localparam logic [1:0] ST_INVAL = 2'b10;
    localparam logic [1:0] ST_OVF   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;

    logic [BAL_W-1:0] bal [NUM_ACCOUNTS];

    // Latched request payload
    logic [1:0]       op_q;
    logic [AW-1:0]    src_q;
    logic [AW-1:0]    dst_q;
    logic [BAL_W-1:0] amt_q;

    // Evaluation results for the request held in EXEC
    logic             src_ok;
    logic             dst_ok;
    logic             amt_ok;
    logic [BAL_W-1:0] src_bal;
    logic [BAL_W-1:0] dst_bal;
    logic [BAL_W:0]   sum_src;
    logic [BAL_W:0]   sum_dst;
    logic [1:0]       ev_status;
    logic [BAL_W-1:0] ev_balance;
    logic [BAL_W-1:0] new_src;
    logic [BAL_W-1:0] new_dst;
    logic             wr_src;
    logic             wr_dst;
    logic             count_inc;

    assign dbg_state = state;

    // Decide status and balance updates for the latched request
    always_comb begin
        src_ok     = int'(src_q) < NUM_ACCOUNTS;
        dst_ok     = int'(dst_q) < NUM_ACCOUNTS;
        amt_ok     = amt_q <= WD_LIMIT;
        src_bal    = src_ok ? bal[src_q] : '0;
        dst_bal    = dst_ok ? bal[dst_q] : '0;
        sum_src    = {1'b0, src_bal} + {1'b0, amt_q};
        sum_dst    = {1'b0, dst_bal} + {1'b0, amt_q};
        ev_status  = ST_OK;
        new_src    = src_bal;
        new_dst    = dst_bal;
        wr_src     = 1'b0;
        wr_dst     = 1'b0;
        case (op_q)
            OP_BAL: begin
                if (!src_ok) ev_status = ST_INVAL;
            end
            OP_WD: begin
                if (!src_ok || !amt_ok) begin
                    ev_status = ST_INVAL;
                end else if (amt_q > src_bal) begin
                    ev_status = ST_INSUF;
                end else begin
                    new_src = src_bal - amt_q;
                    wr_src  = 1'b1;
                end
            end
            OP_DEP: begin
                if (!src_ok) begin
                    ev_status = ST_INVAL;
                end else if (sum_src[BAL_W]) begin
                    ev_status = ST_OVF;
                end else begin
                    new_src = sum_src[BAL_W-1:0];
                    wr_src  = 1'b1;
                end
            end
            default: begin
                // Transfer: funds are checked before destination overflow,
                // and both accounts move together or not at all.
                if (!src_ok || !dst_ok || (dst_q == src_q) || !amt_ok) begin
                    ev_status = ST_INVAL;
                end else if (amt_q > src_bal) begin
                    ev_status = ST_INSUF;
                end else if (sum_dst[BAL_W]) begin
                    ev_status = ST_OVF;
                end else begin
                    new_src = src_bal - amt_q;
                    new_dst = sum_dst[BAL_W-1:0];
                    wr_src  = 1'b1;
                    wr_dst  = 1'b1;
                end
            end
        endcase
        ev_balance = new_src;
        count_inc  = (ev_status == ST_OK) && (op_q != OP_BAL);
    end

    // Request FSM, ledger writes and registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_status  <= ST_OK;
            resp_balance <= '0;
            txn_count    <= '0;
            op_q         <= OP_BAL;
            src_q        <= '0;
            dst_q        <= '0;
            amt_q        <= '0;
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                bal[i] <= INIT_BAL;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        src_q     <= req_src;
                        dst_q     <= req_dst;
                        amt_q     <= req_amt;
                        req_ready <= 1'b0;
                        state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (wr_src) bal[src_q] <= new_src;
                    if (wr_dst) bal[dst_q] <= new_dst;
                    if (count_inc) txn_count <= txn_count + 16'd1;
                    resp_status  <= ev_status;
                    resp_balance <= ev_balance;
                    resp_valid   <= 1'b1;
                    state        <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atm_ledger.sv
// tb_atm_ledger: directed checks of the ATM ledger with hand-computed values.
module tb_atm_ledger;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [3:0]  req_src;
    logic [3:0]  req_dst;
    logic [9:0]  req_amt;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_status;
    logic [9:0]  resp_balance;
    logic [15:0] txn_count;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [1:0] held_status;
    logic [9:0] held_balance;

    atm_ledger dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_src      (req_src),
        .req_dst      (req_dst),
        .req_amt      (req_amt),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_status  (resp_status),
        .resp_balance (resp_balance),
        .txn_count    (txn_count),
        .dbg_state    (dbg_state)
    );

    // Clock: 10 ns period, inputs driven and outputs sampled on falling edges
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog in case the sequence never reaches its summary
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, check latency, check response, handshake
    task automatic xact(input string tag, input logic [1:0] op, input logic [3:0] src,
                        input logic [3:0] dst, input logic [9:0] amt,
                        input logic [1:0] exp_st, input logic [9:0] exp_bal);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_src   = src;
        req_dst   = dst;
        req_amt   = amt;
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_status"}, 32'(resp_status), 32'(exp_st));
        chk({tag, "_bal"}, 32'(resp_balance), 32'(exp_bal));
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, "_done"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_src    = '0;
        req_dst    = '0;
        req_amt    = '0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_status", 32'(resp_status), 32'd0);
        chk("rst_balance", 32'(resp_balance), 32'd0);
        chk("rst_txn", 32'(txn_count), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);

        // Balance query
        xact("q3", 2'b00, 4'd3, 4'd0, 10'd0, 2'b00, 10'd214);
        chk("q3_txn", 32'(txn_count), 32'd0);

        // Withdraw full balance, then one more
        xact("wd214", 2'b01, 4'd5, 4'd0, 10'd214, 2'b00, 10'd0);
        xact("wd1", 2'b01, 4'd5, 4'd0, 10'd1, 2'b01, 10'd0);
        chk("wd_txn", 32'(txn_count), 32'd1);
        xact("wd_lim", 2'b01, 4'd0, 4'd0, 10'd501, 2'b10, 10'd214);
        xact("wd_500", 2'b01, 4'd0, 4'd0, 10'd500, 2'b01, 10'd214);

        // Deposit overflow, exact fill, zero amount, one past full
        xact("dep900", 2'b10, 4'd2, 4'd0, 10'd900, 2'b11, 10'd214);
        xact("dep809", 2'b10, 4'd2, 4'd0, 10'd809, 2'b00, 10'd1023);
        xact("dep0", 2'b10, 4'd2, 4'd0, 10'd0, 2'b00, 10'd1023);
        chk("dep_txn", 32'(txn_count), 32'd3);
        xact("dep1", 2'b10, 4'd2, 4'd0, 10'd1, 2'b11, 10'd1023);

        // Transfers
        xact("xf100", 2'b11, 4'd1, 4'd7, 10'd100, 2'b00, 10'd114);
        xact("q7", 2'b00, 4'd7, 4'd0, 10'd0, 2'b00, 10'd314);
        xact("xf_self", 2'b11, 4'd1, 4'd1, 10'd5, 2'b10, 10'd114);
        xact("xf_lim", 2'b11, 4'd1, 4'd7, 10'd600, 2'b10, 10'd114);
        xact("xf_insuf", 2'b11, 4'd1, 4'd7, 10'd500, 2'b01, 10'd114);
        xact("xf_ovf", 2'b11, 4'd7, 4'd2, 10'd10, 2'b11, 10'd314);
        xact("xf_prio", 2'b11, 4'd5, 4'd2, 10'd1, 2'b01, 10'd0);
        xact("q2", 2'b00, 4'd2, 4'd0, 10'd0, 2'b00, 10'd1023);
        xact("q7b", 2'b00, 4'd7, 4'd0, 10'd0, 2'b00, 10'd314);
        chk("xf_txn", 32'(txn_count), 32'd4);

        // Backpressure: response held while a second request waits
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_src   = 4'd0;
        req_dst   = 4'd0;
        req_amt   = 10'd0;
        @(negedge clk);
        req_op  = 2'b10;
        req_amt = 10'd1;
        @(negedge clk);
        chk("bp_valid", 32'(resp_valid), 32'd1);
        chk("bp_status", 32'(resp_status), 32'd0);
        chk("bp_bal", 32'(resp_balance), 32'd214);
        held_status  = resp_status;
        held_balance = resp_balance;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
            chk("bp_hold_valid", 32'(resp_valid), 32'd1);
            chk("bp_hold_status", 32'(resp_status), 32'(held_status));
            chk("bp_hold_bal", 32'(resp_balance), 32'(held_balance));
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp_hs_valid", 32'(resp_valid), 32'd0);
        chk("bp_hs_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_b_accepted", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("bp_b_valid", 32'(resp_valid), 32'd1);
        chk("bp_b_status", 32'(resp_status), 32'd0);
        chk("bp_b_bal", 32'(resp_balance), 32'd215);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp_txn", 32'(txn_count), 32'd5);

        // Reset while a withdraw is executing
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_src   = 4'd4;
        req_dst   = 4'd0;
        req_amt   = 10'd50;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rx_in_exec", 32'(dbg_state), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rx_resp_valid", 32'(resp_valid), 32'd0);
        chk("rx_req_ready", 32'(req_ready), 32'd1);
        chk("rx_txn", 32'(txn_count), 32'd0);
        @(negedge clk);
        chk("rx_no_resp", 32'(resp_valid), 32'd0);
        xact("rx_q4", 2'b00, 4'd4, 4'd0, 10'd0, 2'b00, 10'd214);
        xact("rx_q2", 2'b00, 4'd2, 4'd0, 10'd0, 2'b00, 10'd214);
        chk("rx_txn_end", 32'(txn_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
